// File: rtl/fancypwm_multi.sv
// ---------------------------------------------------------------------------
// fancypwm_multi
//   Multi-channel PWM engine driven from one shared, prescaled time base.
//   Three output modes: edge-aligned (optional per-channel phase stagger),
//   center-aligned and first-order sigma-delta. Each channel's duty is
//   double-buffered: writes land in a shadow register and move into the
//   active register only at a period boundary, so a period is never glitched.
//
// Ports
//   CLOCK_50     system clock, rising edge
//   rst_n        asynchronous active-low reset
//   prescale     a tick fires every prescale+1 clocks
//   mode         0 edge, 1 center, 2 sigma-delta, 3 reserved (edge)
//   stagger      edge-mode phase stagger enable
//   wr_en        shadow duty write strobe
//   wr_ch        target channel for the write
//   wr_duty      duty value to write
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-clock pulse on every period boundary
// ---------------------------------------------------------------------------
module fancypwm_multi #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  parameter  int PRE_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [1:0]          mode,
  input  logic                stagger,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [1:0]       MODE_EDGE   = 2'd0;
  localparam logic [1:0]       MODE_CENTER = 2'd1;
  localparam logic [1:0]       MODE_SD     = 2'd2;
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             down;
  logic             down_nxt;
  logic [1:0]       mode_q;
  logic             stagger_q;
  logic [1:0]       mode_in;
  logic             boundary;
  logic             mode_chg;
  logic [1:0]       mode_eff;
  logic             stagger_eff;

  // '>=' rather than '==' so that lowering prescale below the running count
  // wraps on the very next clock instead of running through 2^PRE_W.
  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Reserved mode 3 is folded into edge so it never counts as a mode change.
  assign mode_in = (mode == 2'd3) ? MODE_EDGE : mode;

  // Next base-counter value. Center mode bounces 0..MAX..1 using the down
  // flag; the other modes free-run and wrap.
  always_comb begin
    cnt_nxt  = cnt + WIDTH'(1);
    down_nxt = down;
    if (mode_q == MODE_CENTER) begin
      if (down) begin
        cnt_nxt = cnt - WIDTH'(1);
        if (cnt_nxt == '0) down_nxt = 1'b0;
      end else if (cnt_nxt == CNT_MAX) begin
        down_nxt = 1'b1;
      end
    end
  end

  assign boundary = tick && (cnt_nxt == '0);
  assign mode_chg = boundary && (mode_in != mode_q);

  // The boundary tick is the first sample of the new period, so it is
  // already evaluated with the freshly latched mode, stagger and duties.
  assign mode_eff    = boundary ? mode_in : mode_q;
  assign stagger_eff = boundary ? stagger : stagger_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      down        <= 1'b0;
      mode_q      <= MODE_EDGE;
      stagger_q   <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (tick) begin
        // cnt_nxt is already zero at a boundary; only the direction needs
        // forcing so a new mode always starts counting upwards.
        cnt  <= cnt_nxt;
        down <= mode_chg ? 1'b0 : down_nxt;
      end
      if (boundary) begin
        mode_q    <= mode_in;
        stagger_q <= stagger;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    // Stagger offset k * 2^WIDTH / CHANNELS, evaluated at elaboration.
    localparam logic [WIDTH-1:0] OFS =
      WIDTH'(longint'(k) * ((longint'(1) << WIDTH) / longint'(CHANNELS)));

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] duty_eff;
    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   acc_sum;
    logic             out_q;
    logic             out_nxt;

    always_comb begin
      duty_eff = boundary ? shadow : active;
      phase    = cnt_nxt + (stagger_eff ? OFS : '0);
      acc_base = mode_chg ? '0 : acc;
      acc_sum  = {1'b0, acc_base} + {1'b0, duty_eff};
      case (mode_eff)
        MODE_CENTER: out_nxt = (cnt_nxt < duty_eff);
        MODE_SD:     out_nxt = acc_sum[WIDTH];
        default:     out_nxt = (phase < duty_eff);
      endcase
    end

    // Comparing against this channel's own index also drops any wr_ch that
    // does not name an existing channel.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
      end else if (wr_en && (wr_ch == CH_W'(k))) begin
        shadow <= wr_duty;
      end
    end

    // The accumulator carry is not stored: it is the output bit itself.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        active <= '0;
        acc    <= '0;
        out_q  <= 1'b0;
      end else begin
        if (boundary) active <= shadow;
        if (tick) begin
          out_q <= out_nxt;
          if (mode_eff == MODE_SD) begin
            acc <= acc_sum[WIDTH-1:0];
          end else if (mode_chg) begin
            acc <= '0;
          end
        end
      end
    end

    assign pwm_out[k] = out_q;
  end

endmodule

// File: tb/tb_fancypwm_multi.sv
module tb_fancypwm_multi;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int PW = 8;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n    = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [1:0]    mode     = 2'd0;
  logic          stagger  = 1'b0;
  logic          wr_en    = 1'b0;
  logic [1:0]    wr_ch    = '0;
  logic [W-1:0]  wr_duty  = '0;
  wire  [CH-1:0] pwm_out;
  wire           period_tick;

  fancypwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .prescale    (prescale),
    .mode        (mode),
    .stagger     (stagger),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [CH-1:0] o;
    logic          t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   d_sh[CH];
  int   d_act[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected output of channel k on tick n of a period sequence, straight
  // from the mode definitions (n counts ticks from the aligning boundary).
  function automatic logic exp_bit(input int md, input int stg, input int n,
                                   input int k, input int d);
    int pos, c, ph;
    case (md)
      1: begin
        pos = n % 30;
        c   = (pos <= 15) ? pos : 30 - pos;
        return c < d;
      end
      2: return (((n + 1) * d) / 16) != ((n * d) / 16);
      default: begin
        ph = ((n % 16) + (stg != 0 ? k * 4 : 0)) % 16;
        return ph < d;
      end
    endcase
  endfunction

  function automatic logic exp_bnd(input int md, input int n);
    return (md == 1) ? (n % 30 == 0) : (n % 16 == 0);
  endfunction

  task automatic wr(input int ch, input int val);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = W'(val);
    @(posedge CLOCK_50); #1;
    wr_en   = 1'b0;
    d_sh[ch] = val;
  endtask

  task automatic sync();
    for (int i = 0; i < 400; i++) begin
      @(posedge CLOCK_50); #1;
      if (period_tick === 1'b1) return;
    end
    chk("sync_timeout", 32'd0, 32'd1);
  endtask

  // Aligns to the next boundary and then checks every clock for ncyc clocks,
  // with up to two scheduled writes (cycle index -1 means none).
  task automatic run_seg(input string name, input int ncyc, input int md, input int stg,
                         input int pr, input int w1c, input int w1ch, input int w1v,
                         input int w2c, input int w2ch, input int w2v);
    exp_t e, g;
    int   n;
    logic bnd;
    sync();
    for (int k = 0; k < CH; k++) d_act[k] = d_sh[k];
    for (int p = 0; p < ncyc; p++) begin
      wr_en = 1'b0;
      if (p == w1c) begin
        wr_en = 1'b1; wr_ch = 2'(w1ch); wr_duty = W'(w1v);
      end else if (p == w2c) begin
        wr_en = 1'b1; wr_ch = 2'(w2ch); wr_duty = W'(w2v);
      end
      n   = p / (pr + 1);
      bnd = (p % (pr + 1) == 0) && exp_bnd(md, n);
      if (bnd && p > 0) for (int k = 0; k < CH; k++) d_act[k] = d_sh[k];
      for (int k = 0; k < CH; k++) e.o[k] = exp_bit(md, stg, n, k, d_act[k]);
      e.t = bnd;
      if (p == w1c) d_sh[w1ch] = w1v;
      if (p == w2c) d_sh[w2ch] = w2v;
      sb.push_back(e);
      if (p > 0) begin
        @(posedge CLOCK_50); #1;
      end
      g = sb.pop_front();
      chk($sformatf("%s_out_p%0d", name, p), 32'(pwm_out), 32'(g.o));
      chk($sformatf("%s_tick_p%0d", name, p), 32'(period_tick), 32'(g.t));
    end
    wr_en = 1'b0;
  endtask

  task automatic first_boundary(input string name);
    int i;
    i = 0;
    while (i < 40) begin
      @(posedge CLOCK_50); #1;
      i++;
      if (period_tick === 1'b1) break;
    end
    chk(name, 32'(i), 32'd16);
  endtask

  initial begin
    for (int k = 0; k < CH; k++) begin
      d_sh[k]  = 0;
      d_act[k] = 0;
    end

    // reset state
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_out", 32'(pwm_out), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    first_boundary("first_boundary");

    // edge mode, aligned, duty 5 everywhere
    for (int k = 0; k < CH; k++) wr(k, 5);
    run_seg("edge", 32, 0, 0, 0, -1, 0, 0, -1, 0, 0);

    // edge mode with stagger
    sync();
    stagger = 1'b1;
    run_seg("stagger", 32, 0, 1, 0, -1, 0, 0, -1, 0, 0);

    // center mode
    sync();
    stagger = 1'b0;
    mode    = 2'd1;
    run_seg("center", 60, 1, 0, 0, -1, 0, 0, -1, 0, 0);

    // sigma-delta with duties 4, 0, 15, 5
    sync();
    mode = 2'd2;
    wr(0, 4);
    wr(1, 0);
    wr(2, 15);
    wr(3, 5);
    run_seg("sd", 48, 2, 0, 0, -1, 0, 0, -1, 0, 0);

    // prescaled edge mode, mid-period write and write on a boundary
    sync();
    mode     = 2'd0;
    prescale = 8'd3;
    for (int k = 0; k < CH; k++) wr(k, 2);
    run_seg("pre", 200, 0, 0, 3, 20, 0, 8, 128, 1, 12);

    // reset in the middle of a period
    sync();
    prescale = 8'd0;
    sync();
    chk("pre_reset_high", 32'(pwm_out), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", 32'(pwm_out), 32'd0);
    chk("async_reset_tick", 32'(period_tick), 32'd0);
    for (int k = 0; k < CH; k++) d_sh[k] = 0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    first_boundary("first_boundary_after_reset");
    run_seg("post_reset_low", 40, 0, 0, 0, -1, 0, 0, -1, 0, 0);
    sync();
    wr(0, 3);
    run_seg("post_reset_duty", 32, 0, 0, 0, -1, 0, 0, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
